ram_arbiter: RTL and testbench

- Shares the single 16x16 memory between two requesters: the CPU sequencer (port 0) and the LCD refresh/readback logic (port 1).
- Drives the memory's operation, address and data_in inputs, and returns data_out with a one-cycle acknowledge per transaction.
- Uses round-robin arbitration, a per-transaction timeout, and a mandatory IDLE release phase so the memory re-arms between operations.
- Sits between the requesters and the memory instance; the memory sees exactly one master.

---
 rtl/ram_arbiter.sv | 130 +++++++++++++
 tb/tb_ram_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one 16x16 memory between the CPU sequencer
// (port 0) and the LCD refresh/readback logic (port 1).
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   reqN_valid/op/addr/wdata  request from port N (op: 0 IDLE,1 GET,2 SET,3 RESET)
//   reqN_ack/err/rdata        one-cycle completion pulse, timeout flag, read data
//   ram_op/addr/wdata         registered command to the memory
//   ram_rdata, ram_done       memory read data and done level
//   busy                      arbiter not in ARB_IDLE
//   last_grant                most recently granted port
module ram_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [1:0]  req0_op,
    input  logic [3:0]  req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ack,
    output logic        req0_err,
    output logic [15:0] req0_rdata,
    input  logic        req1_valid,
    input  logic [1:0]  req1_op,
    input  logic [3:0]  req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ack,
    output logic        req1_err,
    output logic [15:0] req1_rdata,
    output logic [1:0]  ram_op,
    output logic [3:0]  ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic        ram_done,
    output logic        busy,
    output logic        last_grant
);

    typedef enum logic [1:0] {
        ARB_IDLE,
        WAIT_DONE,
        RELEASE
    } state_t;

    localparam logic [1:0]    OP_GET   = 2'd1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          gnt;
    logic          v0;
    logic          v1;
    logic          pick;
    logic          fin;

    // An IDLE opcode carries no work, so it never competes for the memory.
    assign v0 = req0_valid && (req0_op != 2'd0);
    assign v1 = req1_valid && (req1_op != 2'd0);

    // On contention the port that did not win last time goes next.
    assign pick = (v0 && v1) ? ~last_grant : v1;

    // Done beats a coinciding timeout.
    assign fin = ram_done || (cnt == CNT_LAST);

    assign busy = (state != ARB_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            cnt        <= '0;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            ram_op     <= 2'd0;
            ram_addr   <= 4'd0;
            ram_wdata  <= 16'd0;
            req0_ack   <= 1'b0;
            req0_err   <= 1'b0;
            req0_rdata <= 16'd0;
            req1_ack   <= 1'b0;
            req1_err   <= 1'b0;
            req1_rdata <= 16'd0;
        end else begin
            req0_ack <= 1'b0;
            req0_err <= 1'b0;
            req1_ack <= 1'b0;
            req1_err <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (v0 || v1) begin
                        gnt        <= pick;
                        last_grant <= pick;
                        ram_op     <= pick ? req1_op    : req0_op;
                        ram_addr   <= pick ? req1_addr  : req0_addr;
                        ram_wdata  <= pick ? req1_wdata : req0_wdata;
                        cnt        <= '0;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    cnt <= cnt + 1'b1;
                    if (fin) begin
                        if (gnt) begin
                            req1_ack <= 1'b1;
                            req1_err <= ~ram_done;
                            if (ram_done && ram_op == OP_GET)
                                req1_rdata <= ram_rdata;
                        end else begin
                            req0_ack <= 1'b1;
                            req0_err <= ~ram_done;
                            if (ram_done && ram_op == OP_GET)
                                req0_rdata <= ram_rdata;
                        end
                        ram_op <= 2'd0;
                        state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Memory must drop done before it can accept a new op.
                    if (!ram_done)
                        state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: memory model plus reference
// model of grant order, ack timing, error flag and read data.
module tb_ram_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [1:0]  req0_op = 2'd0;
    logic [3:0]  req0_addr = 4'd0;
    logic [15:0] req0_wdata = 16'd0;
    logic        req0_ack;
    logic        req0_err;
    logic [15:0] req0_rdata;
    logic        req1_valid = 1'b0;
    logic [1:0]  req1_op = 2'd0;
    logic [3:0]  req1_addr = 4'd0;
    logic [15:0] req1_wdata = 16'd0;
    logic        req1_ack;
    logic        req1_err;
    logic [15:0] req1_rdata;
    logic [1:0]  ram_op;
    logic [3:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'd0;
    logic        ram_done = 1'b0;
    logic        busy;
    logic        last_grant;

    ram_arbiter #(.TIMEOUT(TO), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ack(req0_ack), .req0_err(req0_err),
        .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_op(req1_op),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ack(req1_ack), .req1_err(req1_err),
        .req1_rdata(req1_rdata),
        .ram_op(ram_op), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_done(ram_done), .busy(busy),
        .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    // Memory model: done rises lat cycles after an op appears (lat 0 =
    // never) and stays high hold cycles after the op is withdrawn.
    logic [15:0] mem [16];
    int lat = 1;
    int hold = 0;
    int mcnt = 0;
    int hcnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_done <= 1'b0;
            mcnt     <= 0;
            hcnt     <= 0;
        end else if (ram_op != 2'd0) begin
            if (!ram_done) begin
                mcnt <= mcnt + 1;
                if (lat != 0 && mcnt + 1 >= lat) begin
                    ram_done <= 1'b1;
                    hcnt     <= hold;
                    case (ram_op)
                        2'd1: ram_rdata <= mem[ram_addr];
                        2'd2: mem[ram_addr] <= ram_wdata;
                        default: for (int i = 0; i < 16; i++) mem[i] <= 16'd0;
                    endcase
                end
            end
        end else begin
            mcnt <= 0;
            if (ram_done) begin
                if (hcnt == 0) ram_done <= 1'b0;
                else hcnt <= hcnt - 1;
            end
        end
    end

    // Reference state
    logic [15:0] ref_mem [16];
    logic [15:0] rdm [2];
    int lg = 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        int c = 0;
        while ((busy || ram_done) && c < 30) begin
            @(negedge clk);
            c++;
        end
        chk("settle_busy", {31'd0, busy}, 0);
    endtask

    task automatic ref_apply(input int p, input logic [1:0] o,
                             input logic [3:0] a, input logic [15:0] w);
        case (o)
            2'd1: rdm[p] = ref_mem[a];
            2'd2: ref_mem[a] = w;
            default: for (int i = 0; i < 16; i++) ref_mem[i] = 16'd0;
        endcase
    endtask

    task automatic run(input bit v0, input bit v1,
                       input logic [1:0] o0, input logic [1:0] o1,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [15:0] w0, input logic [15:0] w1,
                       input int lt, input int hd);
        bit pend [2];
        logic [1:0] op [2];
        logic [3:0] ad [2];
        logic [15:0] wd [2];
        logic ackv [2];
        logic errv [2];
        int first;
        int nacks;
        int cyc;
        bit rel;
        bit e;
        settle();
        lat = lt;
        hold = hd;
        op[0] = o0; op[1] = o1;
        ad[0] = a0; ad[1] = a1;
        wd[0] = w0; wd[1] = w1;
        pend[0] = v0 && (o0 != 2'd0);
        pend[1] = v1 && (o1 != 2'd0);
        first = (pend[0] && pend[1]) ? 1 - lg : (pend[0] ? 0 : 1);
        req0_valid = v0; req0_op = o0; req0_addr = a0; req0_wdata = w0;
        req1_valid = v1; req1_op = o1; req1_addr = a1; req1_wdata = w1;
        if (!pend[0] && !pend[1]) begin
            repeat (3) @(negedge clk);
            chk("idle_op_busy", {31'd0, busy}, 0);
            chk("idle_op_ramop", {30'd0, ram_op}, 0);
        end
        cyc = 0;
        nacks = 0;
        rel = 0;
        while ((pend[0] || pend[1]) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("grant_op", {30'd0, ram_op}, {30'd0, op[first]});
                chk("grant_addr", {28'd0, ram_addr}, {28'd0, ad[first]});
                chk("grant_wdata", {16'd0, ram_wdata}, {16'd0, wd[first]});
                chk("grant_busy", {31'd0, busy}, 1);
            end
            chk("dual_ack", {31'd0, req0_ack & req1_ack}, 0);
            if (rel) begin
                chk("release_noop", {30'd0, ram_op}, 0);
                if (!ram_done) rel = 0;
            end
            ackv[0] = req0_ack; ackv[1] = req1_ack;
            errv[0] = req0_err; errv[1] = req1_err;
            for (int p = 0; p < 2; p++) begin
                if (ackv[p]) begin
                    chk("ack_expected", {31'd0, pend[p]}, 1);
                    if (nacks == 0) begin
                        chk("order", p, first);
                        chk("latency", cyc, (lt == 0) ? TO + 1 : lt + 2);
                    end
                    e = (lt == 0);
                    chk("err", {31'd0, errv[p]}, {31'd0, e});
                    if (!e) ref_apply(p, op[p], ad[p], wd[p]);
                    chk("rdata0", {16'd0, req0_rdata}, {16'd0, rdm[0]});
                    chk("rdata1", {16'd0, req1_rdata}, {16'd0, rdm[1]});
                    chk("last_grant", {31'd0, last_grant}, p);
                    chk("ack_ramop", {30'd0, ram_op}, 0);
                    lg = p;
                    pend[p] = 0;
                    if (p == 0) req0_valid = 1'b0;
                    else req1_valid = 1'b0;
                    nacks++;
                    rel = 1;
                end
            end
        end
        chk("no_ack_timeout", {30'd0, pend[1], pend[0]}, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        settle();
    endtask

    int lt_tab [6] = '{0, 1, 2, 3, 5, 7};

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = 16'd0;
            ref_mem[i] = 16'd0;
        end
        rdm[0] = 16'd0;
        rdm[1] = 16'd0;
        #12;
        chk("rst_state_busy", {31'd0, busy}, 0);
        chk("rst_ramop", {30'd0, ram_op}, 0);
        chk("rst_lg", {31'd0, last_grant}, 1);
        chk("rst_acks", {30'd0, req1_ack, req0_ack}, 0);
        chk("rst_rdata", {req1_rdata, req0_rdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // port 0 SET, then port 1 GET of the same word
        run(1, 0, 2'd2, 2'd0, 4'd3, 4'd0, 16'h0041, 16'd0, 2, 0);
        run(0, 1, 2'd0, 2'd1, 4'd0, 4'd3, 16'd0, 16'd0, 2, 0);
        chk("get_0041", {16'd0, req1_rdata}, 32'h0041);
        chk("rdata0_keep", {16'd0, req0_rdata}, 0);

        // contention, alternating grants
        for (int k = 0; k < 4; k++)
            run(1, 1, 2'd2, 2'd1, 4'(k), 4'(k), 16'(k + 16'h100),
                16'd0, 1, 0);

        // timeout, then normal service
        run(1, 0, 2'd1, 2'd0, 4'd3, 4'd0, 16'd0, 16'd0, 0, 0);
        run(1, 0, 2'd1, 2'd0, 4'd3, 4'd0, 16'd0, 16'd0, 1, 0);

        // done held long in RELEASE; done coinciding with timeout
        run(1, 1, 2'd2, 2'd1, 4'd7, 4'd7, 16'hbeef, 16'd0, 1, 3);
        run(1, 0, 2'd1, 2'd0, 4'd7, 4'd0, 16'd0, 16'd0, TO - 1, 0);

        // IDLE opcode is not a request
        run(1, 1, 2'd1, 2'd0, 4'd7, 4'd2, 16'd0, 16'd0, 1, 0);
        run(0, 1, 2'd0, 2'd0, 4'd0, 4'd2, 16'd0, 16'd0, 1, 0);

        // reset during WAIT_DONE of port 0 RESET
        lat = 0;
        hold = 0;
        req0_valid = 1'b1; req0_op = 2'd3; req0_addr = 4'd5;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ramop", {30'd0, ram_op}, 0);
        chk("mid_rst_addr", {28'd0, ram_addr}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_lg", {31'd0, last_grant}, 1);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_noack", {30'd0, req1_ack, req0_ack}, 0);
        chk("mid_rst_rdata", {req1_rdata, req0_rdata}, 0);
        rst = 1'b0;
        lg = 1;
        rdm[0] = 16'd0;
        rdm[1] = 16'd0;
        run(1, 1, 2'd1, 2'd1, 4'd7, 4'd3, 16'd0, 16'd0, 2, 0);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            run(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
                4'($urandom), 4'($urandom),
                16'($urandom), 16'($urandom),
                lt_tab[$urandom_range(5, 0)], int'($urandom_range(3, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
